// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory-mapped responder.
// Address map, TCTRL bit positions and the timer FSM state type.
package mem_responder_pkg;

  localparam logic [8:0] ADDR_LED   = 9'h100;
  localparam logic [8:0] ADDR_SW    = 9'h104;
  localparam logic [8:0] ADDR_TCNT  = 9'h108;
  localparam logic [8:0] ADDR_TCMP  = 9'h10C;
  localparam logic [8:0] ADDR_TCTRL = 9'h110;

  localparam int TCTRL_EN  = 0;
  localparam int TCTRL_PER = 1;
  localparam int TCTRL_IRQ = 2;
  localparam int TCTRL_STL = 3;
  localparam int TCTRL_STH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// Compare-match timer: TCNT, TCMP, TCTRL and the IDLE/RUN/DONE FSM.
// Ports: clk, rst_n, wr_tcnt/wr_tcmp/wr_tctrl + wdata in; tcnt, tcmp, tctrl, irq out.
module mmio_timer
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_tcnt,
  input  logic        wr_tcmp,
  input  logic        wr_tctrl,
  input  logic [31:0] wdata,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic [31:0] tctrl,
  output logic        irq
);

  timer_state_t state;
  logic         en;
  logic         periodic;
  logic         match;

  assign match = (state == RUN) && (tcnt == tcmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= '0;
      tcmp     <= '1;
      en       <= 1'b0;
      periodic <= 1'b0;
      irq      <= 1'b0;
      state    <= IDLE;
    end else begin
      if (wr_tcmp)
        tcmp <= wdata;

      // CPU load beats the match reload
      if (wr_tcnt)
        tcnt <= wdata;
      else if (match)
        tcnt <= '0;
      else if (state == RUN)
        tcnt <= tcnt + 32'd1;

      // a new match beats a same-cycle clear
      if (match)
        irq <= 1'b1;
      else if (wr_tctrl && wdata[TCTRL_IRQ])
        irq <= 1'b0;

      if (wr_tctrl) begin
        en       <= wdata[TCTRL_EN];
        periodic <= wdata[TCTRL_PER];
        state    <= wdata[TCTRL_EN] ? RUN : IDLE;
      end else if (match && !periodic) begin
        en    <= 1'b0;
        state <= DONE;
      end
    end
  end

  assign tctrl = {27'd0, state, irq, periodic, en};

endmodule

// File: rtl/mem_responder.sv
// Single-cycle data memory plus LED, switch and optional timer MMIO.
// Ports: clk, reset (async, low), MemWrite/Adr/WriteData in, ReadData out,
// Switches in, LEDs out, TimerIRQ out. Timer built only with
// MEM_RESPONDER_TIMER_EN defined.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  Switches,
  output logic [7:0]  LEDs,
  output logic        TimerIRQ
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] idx;
  logic [8:0]    reg_adr;
  logic          hi_ok;
  logic          sel_ram;
  logic          sel_led;
  logic          sel_sw;
  logic [7:0]    led;
  logic [7:0]    sw_q1;
  logic [7:0]    sw_q2;
  logic          unused_bits;

  assign hi_ok   = (Adr[31:9] == 23'd0);
  assign reg_adr = {Adr[8:2], 2'b00};
  assign idx     = Adr[AW+1:2];
  assign sel_ram = hi_ok && !Adr[8];
  assign sel_led = hi_ok && (reg_adr == ADDR_LED);
  assign sel_sw  = hi_ok && (reg_adr == ADDR_SW);

  assign unused_bits = ^Adr[7:0];

  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram)
      ram[idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= '0;
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= Switches;
      sw_q2 <= sw_q1;
      if (MemWrite && sel_led)
        led <= WriteData[7:0];
    end
  end

  assign LEDs = led;

`ifdef MEM_RESPONDER_TIMER_EN
  logic        sel_tcnt;
  logic        sel_tcmp;
  logic        sel_tctrl;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [31:0] tctrl;
  logic        irq;

  assign sel_tcnt  = hi_ok && (reg_adr == ADDR_TCNT);
  assign sel_tcmp  = hi_ok && (reg_adr == ADDR_TCMP);
  assign sel_tctrl = hi_ok && (reg_adr == ADDR_TCTRL);

  mmio_timer u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .wr_tcnt  (MemWrite && sel_tcnt),
    .wr_tcmp  (MemWrite && sel_tcmp),
    .wr_tctrl (MemWrite && sel_tctrl),
    .wdata    (WriteData),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .irq      (irq)
  );

  assign TimerIRQ = irq;
`else
  assign TimerIRQ = 1'b0;
`endif

  always_comb begin
    ReadData = '0;
    unique case (1'b1)
      sel_ram:   ReadData = ram[idx];
      sel_led:   ReadData = {24'd0, led};
      sel_sw:    ReadData = {24'd0, sw_q2};
`ifdef MEM_RESPONDER_TIMER_EN
      sel_tcnt:  ReadData = tcnt;
      sel_tcmp:  ReadData = tcmp;
      sel_tctrl: ReadData = tctrl;
`endif
      default:   ReadData = '0;
    endcase
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, the number of 32-bit data RAM words (power of two, at most 64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset; asserted while 0.
REQ-004 SHALL have port MemWrite, input, 1, CPU store strobe for the current cycle.
REQ-005 SHALL have port Adr, input, 32, CPU byte address (ALU result); Adr[1:0] ignored.
REQ-006 SHALL have port WriteData, input, 32, CPU store data.
REQ-007 SHALL have port ReadData, output, 32, load data for Adr.
REQ-008 SHALL have port Switches, input, 8, asynchronous board switches.
REQ-009 SHALL have port LEDs, output, 8, LED register contents.
REQ-010 SHALL have port TimerIRQ, output, 1, timer status flag.

Function
REQ-011 SHALL decode the map: 0x000-0x0FF RAM (word index Adr[7:2] mod RAM_WORDS); 0x100 LED; 0x104 SW; 0x108 TCNT; 0x10C TCMP; 0x110 TCTRL.
REQ-012 SHALL return ReadData combinationally from Adr in the same cycle, with zero wait states, to serve a single-cycle CPU.
REQ-013 SHALL commit writes on the rising clk edge where MemWrite=1; a read of the same address in that cycle returns the old value.
REQ-014 SHALL return 0 for unmapped reads and ignore unmapped writes, with Adr[31:9]!=0 counting as unmapped.
REQ-015 SHALL make LED read/write with LEDs=LED[7:0], and SHALL ignore write bits 31:8, which read as 0.
REQ-016 SHALL make SW read-only, returning the Switches value after a 2-flop synchronizer (2-cycle latency), zero-extended.
REQ-017 SHALL define TCTRL bits as: bit0 EN (rw), bit1 PERIODIC (rw), bit2 IRQ (read; write 1 clears), bits 4:3 state (read-only).
REQ-018 SHALL run a timer FSM with states IDLE=0, RUN=1, DONE=2.
REQ-019 IDLE SHALL hold TCNT, and SHALL move to RUN on the edge after EN is written to 1.
REQ-020 RUN SHALL increment TCNT by 1 per cycle with modulo 2^32 wrap.
REQ-021 In RUN, when TCNT==TCMP, the timer SHALL set IRQ and load TCNT=0; with PERIODIC=1 it stays in RUN, otherwise it moves to DONE and clears EN.
REQ-022 DONE SHALL hold TCNT, and SHALL move to RUN when EN is written to 1.
REQ-023 Writing EN=0 SHALL move the FSM to IDLE from any state on the next edge.
REQ-024 A CPU write to TCNT in the same cycle as a match SHALL take priority over the match load; IRQ is still set.
REQ-025 An IRQ write-1-clear in the same cycle as a new match SHALL leave IRQ=1.
REQ-026 With TCMP=0 and EN=1, a match SHALL occur every cycle in periodic mode.
REQ-027 SHALL drive TimerIRQ = IRQ, registered, with no combinational path from inputs.

Reset
REQ-028 On reset=0 the block SHALL immediately force: LED=0, the sync flops=0, TCNT=0, TCMP=0xFFFFFFFF, EN=0, PERIODIC=0, IRQ=0, FSM=IDLE, LEDs=0, TimerIRQ=0.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 Reset asserted mid-count SHALL abort the count; no match is reported after release.

Configuration
REQ-031 With macro MEM_RESPONDER_TIMER_EN defined, the timer (REQ-017..027) SHALL be built as specified.
REQ-032 Without MEM_RESPONDER_TIMER_EN, 0x108-0x110 SHALL read 0 and ignore writes, TimerIRQ SHALL be tied to 0, and no timer flops SHALL exist.

Structure
REQ-033 Package mem_responder_pkg SHALL hold the address constants, the TCTRL bit positions, and the timer_state_t enum (IDLE, RUN, DONE).
REQ-034 The timer FSM, TCNT, TCMP and TCTRL SHALL live in sub-module mmio_timer, instantiated under MEM_RESPONDER_TIMER_EN.

Verification
REQ-035 Write 0xDEADBEEF to 0x04 then read 0x04 -> ReadData=0xDEADBEEF; read 0x0C (never written) is don't-care; read 0x200 -> 0.
REQ-036 Write 0x1A5 to 0x100 -> LEDs=0xA5 on the next edge; read 0x100 -> 0x000000A5.
REQ-037 Switches=0x3C -> read 0x104 returns 0x3C from the 2nd edge after the change, and the prior value before that.
REQ-038 Write TCMP=3, then TCTRL=0x1 -> TimerIRQ=1 four cycles after entering RUN, state=DONE, EN=0, TCNT=0; write TCTRL=0x4 -> TimerIRQ=0.
REQ-039 Write TCMP=2, then TCTRL=0x3 -> IRQ set every 3 cycles; a W1C issued on a match cycle leaves IRQ=1.
REQ-040 Reset=0 mid-RUN with TCNT=5 -> all registers return to their reset values asynchronously; build without MEM_RESPONDER_TIMER_EN -> read 0x110 returns 0 and TimerIRQ=0.
